pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic elastic pipeline-stage register for the 5-stage core.
//  - Replaces hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block.
//  - Carries a data bundle and a control bundle under valid/ready handshake, with synchronous flush.
//  - Control bits are forced low in bubbles, so a squashed slot never writes the register file or memory.
// PARAMETERS
//  DW        32  width of data bundle (ALU result, store data, PC+4, rd, ... packed by instantiator)
//  CW        4   width of control bundle (RegWrite, MemWrite, ResultSrc, ...)
//  SKID_ONLY n/a (none; depth fixed by macro below)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  flush      in   1   squash all held entries (branch/jump redirect)
//  in_valid   in   1   upstream slot valid
//  in_ready   out  1   stage can accept this cycle
//  in_data    in   DW  upstream data bundle
//  in_ctrl    in   CW  upstream control bundle
//  out_valid  out  1   downstream slot valid
//  out_ready  in   1   downstream accepts (0 = stall)
//  out_data   out  DW  held data bundle
//  out_ctrl   out  CW  held control; 0 whenever out_valid=0
//  occupancy  out  2   number of held entries (0..2; max 1 without macro)
// BEHAVIOUR
//  - Transfer in:  in_valid & in_ready at rising edge. Transfer out: out_valid & out_ready.
//  - Reset (rst=1 at edge): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid entry cleared.
//    in_ready=1 in the cycle after reset.
//  - Latency: accepted entry appears on out_* the next cycle (1-cycle register). Order strictly FIFO.
//  - With PIPE_SKID_EN: main register M plus skid register S. States:
//     EMPTY (occ 0): accept -> BUSY.
//     BUSY  (occ 1): accept & out -> BUSY (M replaced); accept & !out -> FULL (new word into S);
//                    out & !accept -> EMPTY; neither -> BUSY.
//     FULL  (occ 2): in_ready=0; out -> BUSY (S moves to M, S cleared); !out -> FULL.
//    - in_ready = !S_valid. It is a registered output, with no combinational path from out_ready.
//    - Full throughput: 1 transfer/cycle sustained with out_ready=1.
//  - Stall (out_ready=0) with valid output: out_data/out_ctrl held stable; no drop, no duplicate.
//  - flush=1 at edge: all valids -> 0, out_ctrl -> 0, occupancy -> 0. out_data is don't-care, but is held.
//    - flush dominates a same-cycle accept: the incoming word is discarded.
//    - Any out transfer in that cycle still counts downstream (out_* was valid).
//  - rst dominates flush. Reset mid-stall discards all entries.
//  - Control gating: out_ctrl = out_valid ? M_ctrl : 0 (registered zero, not a combinational AND).
//  - No arithmetic. Widths pass through unchanged. occupancy never exceeds 2.
// CONFIGURATION
//  PIPE_SKID_EN defined:
//   - 2-entry skid buffer as above.
//   - in_ready fully registered; timing path broken between stages.
//  PIPE_SKID_EN undefined:
//   - Single register M, with states EMPTY/BUSY only.
//   - in_ready = out_ready | !out_valid (combinational pass-back).
//   - Same flush/reset/gating rules. occupancy[1] is tied to 0.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1 and in_ctrl=4'hF.
//     -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in_ready=1 after release.
//  2. Streaming: 8 words 0x100..0x107, in_valid=1 and out_ready=1 every cycle.
//     -> outputs 0x100..0x107 in order, 1 cycle late; no bubbles.
//  3. Stall (SKID): words A=0x11, B=0x22, C=0x33 offered; out_ready=0 for 3 cycles.
//     -> out_data=0x11 held; occupancy=2; in_ready=0; C not accepted.
//     Raise out_ready -> 0x11, 0x22, 0x33 in order.
//  4. Flush: occupancy=2 with out_ctrl=4'b1010; flush=1 together with in_valid=1 (0x44).
//     -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x44 never emerges.
//  5. Priority: rst=1 and flush=1 together while FULL.
//     -> reset values; then an accept of 0x55 appears on out_data 1 cycle later.
//  6. No skid: with macro undefined, drop out_ready.
//     -> in_ready falls in the same cycle; single word held; occupancy never above 1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline register with flush and zeroed control in bubbles.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a fully registered in_ready.
module pipe_stage_buf #(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_ctrl,
    output logic [1:0]    occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_nx, grow, shrink;
    logic accept, pop, load_m;
`ifdef PIPE_SKID_EN
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_ctrl;
    assign s_valid   = state == FULL;
    assign in_ready  = !s_valid;
    assign occupancy = state;
    assign grow      = out_valid ? FULL : BUSY;
    assign shrink    = s_valid ? BUSY : EMPTY;
`else
    assign in_ready  = out_ready | !out_valid;
    assign occupancy = {1'b0, state == BUSY};
    assign grow      = BUSY;
    assign shrink    = EMPTY;
`endif
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign load_m    = !out_valid | out_ready;
    always_comb begin
        state_nx = flush ? EMPTY : (accept & !pop) ? grow : (pop & !accept) ? shrink : state;
    end
    always_ff @(posedge clk) begin
        state <= rst ? EMPTY : state_nx;
    end
    // Control is zeroed in the register itself so bubbles never carry stale write enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_ctrl <= '0;
`ifdef PIPE_SKID_EN
            s_data   <= '0;
            s_ctrl   <= '0;
`endif
        end else if (flush) begin
            out_ctrl <= '0;
`ifdef PIPE_SKID_EN
            s_ctrl   <= '0;
`endif
        end else begin
`ifdef PIPE_SKID_EN
            if (load_m) begin
                out_data <= s_valid ? s_data : accept ? in_data : out_data;
                out_ctrl <= s_valid ? s_ctrl : accept ? in_ctrl : '0;
            end
            if (accept & !load_m) begin
                s_data <= in_data;
                s_ctrl <= in_ctrl;
            end else if (pop) begin
                s_ctrl <= '0;
            end
`else
            if (load_m) begin
                out_data <= accept ? in_data : out_data;
                out_ctrl <= accept ? in_ctrl : '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed vector table plus streaming and in_ready sequences for pipe_stage_buf.
module tb_pipe_stage_buf;
`ifdef PIPE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [31:0] in_data = 0, out_data;
    logic [3:0]  in_ctrl = 0, out_ctrl;
    logic [1:0]  occupancy;
    int n_cmp = 0, n_err = 0;

    typedef struct {
        logic        rst, fl, iv, ordy;
        logic [31:0] id;
        logic [3:0]  ic;
        logic        ev, eir, cd;
        logic [31:0] ed;
        logic [3:0]  ec;
        logic [1:0]  eocc;
    } vec_t;
    vec_t vq[$];

    pipe_stage_buf dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic void add(int r, int f, int iv, int id, int ic, int ordy,
                                int ev, int ed, int ec, int eocc, int eir, int cd);
        vec_t v;
        v.rst = r[0]; v.fl = f[0]; v.iv = iv[0]; v.id = id; v.ic = ic[3:0]; v.ordy = ordy[0];
        v.ev = ev[0]; v.ed = ed; v.ec = ec[3:0]; v.eocc = eocc[1:0]; v.eir = eir[0]; v.cd = cd[0];
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic iv, logic [31:0] id, logic [3:0] ic, logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with junk on the input
        add(1,0,1,'hAA,'hF,1, 0,0,0,0,1,1);
        add(1,0,1,'hAA,'hF,1, 0,0,0,0,1,1);
        add(0,0,0,0,0,1,      0,0,0,0,1,1);
        add(0,0,1,5,3,1,      1,5,3,1,1,1);
        add(0,0,0,0,0,1,      0,0,0,0,1,0);
        add(0,0,1,6,9,0,      1,6,9,1,SKID,1);
        add(0,0,0,0,0,0,      1,6,9,1,SKID,1);
        add(0,0,0,0,0,1,      0,0,0,0,1,0);
        add(0,1,1,7,4,1,      0,0,0,0,1,0);
        add(0,0,1,8,2,1,      1,8,2,1,1,1);
        add(0,1,0,0,0,0,      0,0,0,0,1,0);
        // stall: A, B, C offered with out_ready low
`ifdef PIPE_SKID_EN
        add(0,0,1,'h11,1,0,   1,'h11,1,1,1,1);
        add(0,0,1,'h22,2,0,   1,'h11,1,2,0,1);
        add(0,0,1,'h33,3,0,   1,'h11,1,2,0,1);
        add(0,0,1,'h33,3,1,   1,'h22,2,1,1,1);
        add(0,0,1,'h33,3,1,   1,'h33,3,1,1,1);
`else
        add(0,0,1,'h11,1,0,   1,'h11,1,1,0,1);
        add(0,0,1,'h22,2,0,   1,'h11,1,1,0,1);
        add(0,0,1,'h22,2,0,   1,'h11,1,1,0,1);
        add(0,0,1,'h22,2,1,   1,'h22,2,1,1,1);
        add(0,0,1,'h33,3,1,   1,'h33,3,1,1,1);
`endif
        add(0,0,0,0,0,1,      0,0,0,0,1,0);
        // flush while holding entries, with a same-cycle offer of 0x44
        add(0,0,1,'h61,'hA,0, 1,'h61,'hA,1,SKID,1);
        add(0,0,1,'h62,5,0,   1,'h61,'hA,SKID+1,0,1);
        add(0,1,1,'h44,'hF,0, 0,0,0,0,1,0);
        add(0,0,0,0,0,1,      0,0,0,0,1,0);
        add(0,0,0,0,0,1,      0,0,0,0,1,0);
        // rst and flush together while holding entries
        add(0,0,1,'h71,3,0,   1,'h71,3,1,SKID,1);
        add(0,0,1,'h72,'hC,0, 1,'h71,3,SKID+1,0,1);
        add(1,1,1,'h73,'hF,0, 0,0,0,0,1,1);
        add(0,0,1,'h55,6,0,   1,'h55,6,1,SKID,1);
        add(0,0,0,0,0,1,      0,0,0,0,1,0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].id, vq[i].ic, vq[i].ordy);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].ev));
            chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vq[i].ec));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vq[i].eocc));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].eir));
            if (vq[i].cd) chk($sformatf("v%0d_data", i), out_data, vq[i].ed);
        end

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 32'h100 + 32'(i), 4'(i), 1);
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("stream%0d_data", i), out_data, 32'h100 + 32'(i));
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("stream_drain_valid", 32'(out_valid), 0);

        drive(0, 0, 1, 'h99, 1, 0);
        chk("hold_occ", 32'(occupancy), 1);
        out_ready = 1;
        #1 chk("ready_pass_hi", 32'(in_ready), 1);
        out_ready = 0;
        #1 chk("ready_pass_lo", 32'(in_ready), 32'(SKID));
        chk("hold_data", out_data, 'h99);
        drive(0, 0, 0, 0, 0, 1);
        chk("hold_drain_valid", 32'(out_valid), 0);
        chk("hold_drain_occ", 32'(occupancy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
